// File: rtl/regfile_scoreboard_stage.sv
// rtl/regfile_scoreboard_stage.sv - register-file issue stage with busy scoreboard and writeback bypass
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   in_valid/in_ready    decode-side handshake
//   in_rs_sel/rs_used    NUM_RD source indices and per-port hazard participation
//   in_rd_sel/in_rd_we   destination register and write flag
//   in_side              opaque payload, passed through
//   wb_en/addr/data      NUM_WR writeback ports from MEM/WB
//   out_valid/out_ready  execute-side handshake on the issue register
//   out_*                latched source values, indices, destination, payload
//   commit_cnt           running count of writeback-port writes (wraps)
module regfile_scoreboard_stage #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_RD*AW-1:0]   in_rs_sel,
  input  logic [NUM_RD-1:0]      in_rs_used,
  input  logic [AW-1:0]          in_rd_sel,
  input  logic                   in_rd_we,
  input  logic [XLEN-1:0]        in_side,
  input  logic [NUM_WR-1:0]      wb_en,
  input  logic [NUM_WR*AW-1:0]   wb_addr,
  input  logic [NUM_WR*XLEN-1:0] wb_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_RD*XLEN-1:0] out_rs_val,
  output logic [NUM_RD*AW-1:0]   out_rs_sel,
  output logic [AW-1:0]          out_rd_sel,
  output logic                   out_rd_we,
  output logic [XLEN-1:0]        out_side,
  output logic [31:0]            commit_cnt
);

  logic [XLEN-1:0]        regs_q [NUM_REGS];
  logic [XLEN-1:0]        regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]    busy_q, busy_d;
  logic                   out_valid_q, out_valid_d;
  logic [NUM_RD*XLEN-1:0] out_rs_val_q, out_rs_val_d;
  logic [NUM_RD*AW-1:0]   out_rs_sel_q, out_rs_sel_d;
  logic [AW-1:0]          out_rd_sel_q, out_rd_sel_d;
  logic                   out_rd_we_q, out_rd_we_d;
  logic [XLEN-1:0]        out_side_q, out_side_d;
  logic [31:0]            commit_cnt_q, commit_cnt_d;

  logic [NUM_REGS-1:0]    wb_hit;
  logic [NUM_REGS-1:0]    busy_eff;
  logic [31:0]            wb_cnt;
  logic [NUM_RD*XLEN-1:0] rs_val;
  logic                   hazard;
  logic                   accept;

  // Writeback decode: ascending j so the highest port wins on an address collision.
  // Register 0 is never written, so regs_q[0] stays at its reset value of zero.
  always_comb begin
    wb_hit = '0;
    wb_cnt = '0;
    regs_d = regs_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wb_en[j]) begin
        wb_cnt = wb_cnt + 32'd1;
        if (wb_addr[j*AW +: AW] != '0) begin
          wb_hit[wb_addr[j*AW +: AW]] = 1'b1;
          regs_d[wb_addr[j*AW +: AW]] = wb_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  // Read with same-cycle writeback bypass (highest matching port wins).
  always_comb begin
    rs_val = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rs_val[k*XLEN +: XLEN] = regs_q[in_rs_sel[k*AW +: AW]];
      for (int j = 0; j < NUM_WR; j++) begin
        if (wb_en[j] && (wb_addr[j*AW +: AW] == in_rs_sel[k*AW +: AW]) &&
            (in_rs_sel[k*AW +: AW] != '0)) begin
          rs_val[k*XLEN +: XLEN] = wb_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  // A writeback landing this cycle resolves the hazard it clears; busy_q[0] is
  // never set, so index 0 always passes.
  always_comb begin
    busy_eff = busy_q & ~wb_hit;
    hazard   = in_rd_we & busy_eff[in_rd_sel];
    for (int k = 0; k < NUM_RD; k++) begin
      if (in_rs_used[k] && busy_eff[in_rs_sel[k*AW +: AW]]) begin
        hazard = 1'b1;
      end
    end
  end

  assign in_ready = ~hazard & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    busy_d       = busy_eff;
    out_valid_d  = accept | (out_valid_q & ~out_ready);
    out_rs_val_d = out_rs_val_q;
    out_rs_sel_d = out_rs_sel_q;
    out_rd_sel_d = out_rd_sel_q;
    out_rd_we_d  = out_rd_we_q;
    out_side_d   = out_side_q;
    commit_cnt_d = commit_cnt_q + wb_cnt;
    if (accept) begin
      // Set after clear: a newly issued producer owns the register.
      if (in_rd_we && (in_rd_sel != '0)) begin
        busy_d[in_rd_sel] = 1'b1;
      end
      out_rs_val_d = rs_val;
      out_rs_sel_d = in_rs_sel;
      out_rd_sel_d = in_rd_sel;
      out_rd_we_d  = in_rd_we;
      out_side_d   = in_side;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q       <= '0;
      out_valid_q  <= 1'b0;
      out_rs_val_q <= '0;
      out_rs_sel_q <= '0;
      out_rd_sel_q <= '0;
      out_rd_we_q  <= 1'b0;
      out_side_q   <= '0;
      commit_cnt_q <= '0;
    end else begin
      regs_q       <= regs_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      out_rs_val_q <= out_rs_val_d;
      out_rs_sel_q <= out_rs_sel_d;
      out_rd_sel_q <= out_rd_sel_d;
      out_rd_we_q  <= out_rd_we_d;
      out_side_q   <= out_side_d;
      commit_cnt_q <= commit_cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_rs_val = out_rs_val_q;
  assign out_rs_sel = out_rs_sel_q;
  assign out_rd_sel = out_rd_sel_q;
  assign out_rd_we  = out_rd_we_q;
  assign out_side   = out_side_q;
  assign commit_cnt = commit_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard_stage.sv
// tb/tb_regfile_scoreboard_stage.sv - self-checking bench for regfile_scoreboard_stage
module tb_regfile_scoreboard_stage;
  localparam int XLEN = 32;
  localparam int NR   = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            in_valid;
  logic            in_ready;
  logic [NRD*AW-1:0]   in_rs_sel;
  logic [NRD-1:0]      in_rs_used;
  logic [AW-1:0]       in_rd_sel;
  logic                in_rd_we;
  logic [XLEN-1:0]     in_side;
  logic [NWR-1:0]      wb_en;
  logic [NWR*AW-1:0]   wb_addr;
  logic [NWR*XLEN-1:0] wb_data;
  logic                out_valid;
  logic                out_ready;
  logic [NRD*XLEN-1:0] out_rs_val;
  logic [NRD*AW-1:0]   out_rs_sel;
  logic [AW-1:0]       out_rd_sel;
  logic                out_rd_we;
  logic [XLEN-1:0]     out_side;
  logic [31:0]         commit_cnt;

  regfile_scoreboard_stage #(.XLEN(XLEN), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_sel(in_rs_sel), .in_rs_used(in_rs_used),
    .in_rd_sel(in_rd_sel), .in_rd_we(in_rd_we), .in_side(in_side),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs_val(out_rs_val), .out_rs_sel(out_rs_sel),
    .out_rd_sel(out_rd_sel), .out_rd_we(out_rd_we), .out_side(out_side),
    .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic [31:0] m_regs [NR];
  logic [NR-1:0] m_busy;
  logic        m_ov;
  logic [63:0] m_rs_val;
  logic [9:0]  m_rs_sel;
  logic [4:0]  m_rd_sel;
  logic        m_rd_we;
  logic [31:0] m_side;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic wb_writes(input logic [4:0] r);
    logic hit = 1'b0;
    for (int j = 0; j < NWR; j++)
      if (wb_en[j] && wb_addr[j*AW +: AW] == r && r != 0) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    logic [31:0] v;
    if (r == 0) return 32'd0;
    v = m_regs[r];
    for (int j = 0; j < NWR; j++)
      if (wb_en[j] && wb_addr[j*AW +: AW] == r) v = wb_data[j*XLEN +: XLEN];
    return v;
  endfunction

  function automatic logic m_ready();
    logic haz = 1'b0;
    logic [4:0] r;
    for (int k = 0; k < NRD; k++) begin
      r = in_rs_sel[k*AW +: AW];
      if (in_rs_used[k] && r != 0 && m_busy[r] && !wb_writes(r)) haz = 1'b1;
    end
    if (in_rd_we && in_rd_sel != 0 && m_busy[in_rd_sel] && !wb_writes(in_rd_sel)) haz = 1'b1;
    return !haz && (!m_ov || out_ready);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++) m_regs[i] = 32'd0;
    m_busy = '0; m_ov = 1'b0; m_rs_val = '0; m_rs_sel = '0;
    m_rd_sel = '0; m_rd_we = 1'b0; m_side = '0; m_cnt = '0;
  endtask

  task automatic chk_outputs();
    chk("out_valid", out_valid, m_ov);
    chk("out_rs_val", out_rs_val, m_rs_val);
    chk("out_rs_sel", out_rs_sel, m_rs_sel);
    chk("out_rd_sel", out_rd_sel, m_rd_sel);
    chk("out_rd_we", out_rd_we, m_rd_we);
    chk("out_side", out_side, m_side);
    chk("commit_cnt", commit_cnt, m_cnt);
  endtask

  // Called shortly after a posedge with inputs already driven; returns 1 after the next posedge.
  task automatic cycle();
    logic rdy, acc;
    logic [63:0] vals;
    #2;
    rdy = m_ready();
    chk("in_ready", in_ready, rdy);
    acc = in_valid && rdy;
    for (int k = 0; k < NRD; k++) vals[k*32 +: 32] = m_read(in_rs_sel[k*AW +: AW]);
    for (int j = 0; j < NWR; j++) begin
      if (wb_en[j]) begin
        m_cnt = m_cnt + 32'd1;
        if (wb_addr[j*AW +: AW] != 0) begin
          m_regs[wb_addr[j*AW +: AW]] = wb_data[j*XLEN +: XLEN];
          m_busy[wb_addr[j*AW +: AW]] = 1'b0;
        end
      end
    end
    if (acc) begin
      m_rs_val = vals; m_rs_sel = in_rs_sel; m_rd_sel = in_rd_sel;
      m_rd_we = in_rd_we; m_side = in_side; m_ov = 1'b1;
      if (in_rd_we && in_rd_sel != 0) m_busy[in_rd_sel] = 1'b1;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
    chk_outputs();
  endtask

  task automatic set_instr(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                           input logic [1:0] used, input logic [4:0] rd, input logic we,
                           input logic [31:0] side);
    in_valid = v; in_rs_sel = {rs1, rs0}; in_rs_used = used;
    in_rd_sel = rd; in_rd_we = we; in_side = side;
  endtask

  task automatic set_wb(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1);
    wb_en = en; wb_addr = {a1, a0}; wb_data = {d1, d0};
  endtask

  task automatic idle();
    set_instr(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 32'd0);
    set_wb(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    out_ready = 1'b1;
  endtask

  // Asserts reset between clock edges and checks the immediate clear.
  task automatic do_reset();
    resetn = 1'b0;
    #1;
    model_clear();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_commit_cnt", commit_cnt, 32'd0);
    chk("rst_out_rd_sel", out_rd_sel, 5'd0);
    chk("rst_out_rs_val", out_rs_val, 64'd0);
    idle();
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    idle();
    @(posedge clk);
    #1;

    // Reset then idle, read of x5 gives 0
    do_reset();
    chk_outputs();
    set_instr(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 32'h5);
    #1 chk("idle_in_ready", in_ready, 1'b1);
    cycle();
    chk("idle_x5_zero", out_rs_val[31:0], 32'd0);

    // Back-to-back RAW on x3
    do_reset();
    set_instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 32'h30);
    cycle();
    set_instr(1'b1, 5'd3, 5'd0, 2'b01, 5'd0, 1'b0, 32'h31);
    #1 chk("raw_stall", in_ready, 1'b0);
    cycle();
    cycle();
    set_wb(2'b01, 5'd3, 32'hDEADBEEF, 5'd0, 32'd0);
    #1 chk("raw_release", in_ready, 1'b1);
    cycle();
    chk("raw_bypass", out_rs_val[31:0], 32'hDEADBEEF);
    set_wb(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    #1 chk("raw_busy_cleared", in_ready, 1'b1);
    cycle();

    // x0 semantics
    do_reset();
    set_wb(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'd0);
    set_instr(1'b1, 5'd0, 5'd0, 2'b01, 5'd0, 1'b0, 32'h40);
    cycle();
    chk("x0_read_zero", out_rs_val[31:0], 32'd0);
    chk("x0_commit_one", commit_cnt, 32'd1);
    set_wb(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    set_instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 32'h41);
    cycle();
    set_instr(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b1, 32'h42);
    #1 chk("x0_never_busy", in_ready, 1'b1);
    cycle();

    // Dual-write collision on x7
    do_reset();
    set_wb(2'b11, 5'd7, 32'h11, 5'd7, 32'h22);
    set_instr(1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 32'h70);
    cycle();
    chk("dual_bypass", out_rs_val[31:0], 32'h22);
    set_wb(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    set_instr(1'b1, 5'd0, 5'd7, 2'b10, 5'd0, 1'b0, 32'h71);
    cycle();
    chk("dual_stored", out_rs_val[63:32], 32'h22);

    // Backpressure
    do_reset();
    set_instr(1'b1, 5'd1, 5'd2, 2'b11, 5'd10, 1'b0, 32'hAAAA);
    cycle();
    out_ready = 1'b0;
    set_instr(1'b1, 5'd2, 5'd1, 2'b11, 5'd11, 1'b0, 32'hBBBB);
    for (int i = 0; i < 4; i++) begin
      #1 chk("bp_stall", in_ready, 1'b0);
      cycle();
      chk("bp_hold_side", out_side, 32'hAAAA);
    end
    out_ready = 1'b1;
    #1 chk("bp_drain_ready", in_ready, 1'b1);
    cycle();
    chk("bp_next_side", out_side, 32'hBBBB);
    chk("bp_next_valid", out_valid, 1'b1);

    // Set/clear race on x9
    do_reset();
    set_instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 32'h90);
    cycle();
    set_wb(2'b01, 5'd9, 32'h99, 5'd0, 32'd0);
    set_instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 32'h91);
    #1 chk("race_accept", in_ready, 1'b1);
    cycle();
    set_wb(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    set_instr(1'b1, 5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 32'h92);
    #1 chk("race_still_busy", in_ready, 1'b0);
    cycle();
    cycle();
    set_wb(2'b10, 5'd0, 32'd0, 5'd9, 32'h1234);
    #1 chk("race_second_wb", in_ready, 1'b1);
    cycle();
    chk("race_value", out_rs_val[31:0], 32'h1234);

    // Async reset mid-operation
    do_reset();
    out_ready = 1'b0;
    set_wb(2'b01, 5'd1, 32'h5, 5'd0, 32'd0);
    set_instr(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 32'h44);
    cycle();
    chk("ar_pre_valid", out_valid, 1'b1);
    chk("ar_pre_cnt", commit_cnt, 32'd1);
    #2;
    do_reset();
    set_instr(1'b1, 5'd4, 5'd0, 2'b01, 5'd4, 1'b1, 32'h45);
    #1 chk("ar_busy_cleared", in_ready, 1'b1);
    cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      set_instr(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                $urandom);
      set_wb(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), $urandom,
             5'($urandom_range(0, 7)), $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
